pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//   Parametrised inter-stage pipeline register for the 5-stage MIPS core. It replaces the
//   fixed per-stage registers (D/E, E/M, M/W) with one block that carries PC, Instr, a
//   branch-delay flag and NUM_LANES data words. It adds valid tracking, stall (hold) and
//   flush (bubble insert), plus a saturating bubble counter for hazard-unit perf checks.
// PARAMETERS
//   DATA_W        32      width of one data lane (bits)
//   NUM_LANES     3       number of data lanes (e.g. RegData1, RegData2, ExtImm)
//   RESET_PC      32'h0   pc_o value after reset
//   FLUSH_KEEP_PC 1       1: a flushed bubble carries pc_i (EPC source); 0: bubble pc_o = 0
//   CNT_W         16      bubble counter width
// PORTS
//   clk        in   1                   rising-edge clock
//   reset      in   1                   asynchronous, active-low reset
//   stall_i    in   1                   1: hold all state this cycle
//   flush_i    in   1                   1: load a bubble this cycle
//   valid_i    in   1                   upstream slot holds a real instruction
//   pc_i       in   32                  upstream PC
//   instr_i    in   32                  upstream instruction word
//   bd_i       in   1                   upstream instr is in a branch delay slot
//   data_i     in   NUM_LANES*DATA_W    packed lanes; lane k = data_i[k*DATA_W +: DATA_W]
//   clr_cnt_i  in   1                   synchronous clear of bubble_cnt_o
//   valid_o    out  1                   registered valid
//   pc_o       out  32                  registered PC
//   instr_o    out  32                  registered instruction (0 = nop on bubble)
//   bd_o       out  1                   registered delay-slot flag
//   data_o     out  NUM_LANES*DATA_W    registered lanes, same packing as data_i
//   bubble_cnt_o out CNT_W              saturating count of bubble cycles loaded
// BEHAVIOUR
//   - Reset (reset==0, async): valid_o=0, pc_o=RESET_PC, instr_o=0, bd_o=0, data_o=0,
//     bubble_cnt_o=0. Release is sampled at the next rising edge.
//   - Priority at each rising edge: flush_i > stall_i > load.
//   - Load (no flush, no stall): all outputs take their *_i values. Latency is 1 cycle.
//   - Stall (stall_i=1, flush_i=0): every output keeps its value. The counter also holds,
//     but clr_cnt_i still applies.
//   - Flush (flush_i=1, regardless of stall_i): valid_o=0, instr_o=0, bd_o=0, data_o=0.
//     pc_o=pc_i if FLUSH_KEEP_PC==1, else 0.
//   - A bubble cycle is an edge that loads valid_o=0, either by flush or by a load with
//     valid_i=0. On a non-stalled bubble cycle bubble_cnt_o increments by 1 and saturates
//     at {CNT_W{1'b1}} (no wrap).
//   - clr_cnt_i=1 forces bubble_cnt_o to 0 on that edge. This overrides an increment and a stall.
//   - On a load with valid_i=0, pc/instr/bd/data still load verbatim; only valid_o marks the bubble.
//   - No combinational path from any input to any output.
// TESTING
//   1 Reset mid-stream: load pc_i=0x3004, then drive reset=0 asynchronously between edges
//     -> all outputs at reset values immediately, before the next edge.
//   2 Load: valid_i=1, pc_i=0x3000, instr_i=0x24010005, lanes {1,2,3}
//     -> exactly these values on the outputs one edge later, valid_o=1.
//   3 Stall: hold stall_i=1 for 3 edges while the inputs change
//     -> outputs and bubble_cnt_o unchanged for all 3 edges. Release -> new values load.
//   4 Flush+stall on the same edge with pc_i=0x3010
//     -> valid_o=0, instr_o=0, data_o=0, pc_o=0x3010 (FLUSH_KEEP_PC=1); pc_o=0 on a
//     second instance with FLUSH_KEEP_PC=0. bubble_cnt_o +1.
//   5 Counter saturation (CNT_W=4): 20 consecutive flushes -> bubble_cnt_o stops at 15.
//     Then clr_cnt_i=1 together with flush_i=1 -> 0.
//   6 Lane packing (NUM_LANES=4, DATA_W=8): data_i=0xDDCCBBAA -> data_o=0xDDCCBBAA.
//     Lane 2 reads 0xCC.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: inter-stage pipeline register for the 5-stage MIPS core.
// It carries PC, instruction, the branch-delay flag and NUM_LANES data words.
// It also tracks valid, holds on stall, inserts a bubble on flush, and keeps a
// saturating count of bubble cycles so the hazard unit's behaviour can be measured.
module pipe_stage_reg #(
  parameter int          DATA_W        = 32,
  parameter int          NUM_LANES     = 3,
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter bit          FLUSH_KEEP_PC = 1'b1,
  parameter int          CNT_W         = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        stall_i,
  input  logic                        flush_i,
  input  logic                        valid_i,
  input  logic [31:0]                 pc_i,
  input  logic [31:0]                 instr_i,
  input  logic                        bd_i,
  input  logic [NUM_LANES*DATA_W-1:0] data_i,
  input  logic                        clr_cnt_i,
  output logic                        valid_o,
  output logic [31:0]                 pc_o,
  output logic [31:0]                 instr_o,
  output logic                        bd_o,
  output logic [NUM_LANES*DATA_W-1:0] data_o,
  output logic [CNT_W-1:0]            bubble_cnt_o
);

  localparam int DW = NUM_LANES * DATA_W;

  // Increment that sticks at all-ones instead of wrapping back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] res;
    if (v == {CNT_W{1'b1}}) begin
      res = v;
    end else begin
      res = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return res;
  endfunction

  logic             r_valid;
  logic [31:0]      r_pc;
  logic [31:0]      r_instr;
  logic             r_bd;
  logic [DW-1:0]    r_data;
  logic [CNT_W-1:0] r_cnt;

  logic             w_valid_nxt;
  logic [31:0]      w_pc_nxt;
  logic [31:0]      w_instr_nxt;
  logic             w_bd_nxt;
  logic [DW-1:0]    w_data_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_bubble;

  // A bubble is loaded by a flush, or by an unstalled load of an empty slot.
  assign w_bubble = flush_i | (~stall_i & ~valid_i);

  // Next payload: flush beats stall, stall beats load.
  always_comb begin
    w_valid_nxt = r_valid;
    w_pc_nxt    = r_pc;
    w_instr_nxt = r_instr;
    w_bd_nxt    = r_bd;
    w_data_nxt  = r_data;
    if (flush_i) begin
      w_valid_nxt = 1'b0;
      w_pc_nxt    = FLUSH_KEEP_PC ? pc_i : 32'h0000_0000;
      w_instr_nxt = 32'h0000_0000;
      w_bd_nxt    = 1'b0;
      w_data_nxt  = {DW{1'b0}};
    end else if (stall_i) begin
      w_valid_nxt = r_valid;
      w_pc_nxt    = r_pc;
      w_instr_nxt = r_instr;
      w_bd_nxt    = r_bd;
      w_data_nxt  = r_data;
    end else begin
      // An empty slot still loads its payload verbatim; only valid marks it.
      w_valid_nxt = valid_i;
      w_pc_nxt    = pc_i;
      w_instr_nxt = instr_i;
      w_bd_nxt    = bd_i;
      w_data_nxt  = data_i;
    end
  end

  // Next bubble count: clear wins over both increment and hold.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (clr_cnt_i) begin
      w_cnt_nxt = {CNT_W{1'b0}};
    end else if (w_bubble) begin
      w_cnt_nxt = sat_inc(r_cnt);
    end else begin
      w_cnt_nxt = r_cnt;
    end
  end

  // Payload register with asynchronous reset to the idle/nop state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_pc    <= RESET_PC;
      r_instr <= 32'h0000_0000;
      r_bd    <= 1'b0;
      r_data  <= {DW{1'b0}};
    end else begin
      r_valid <= w_valid_nxt;
      r_pc    <= w_pc_nxt;
      r_instr <= w_instr_nxt;
      r_bd    <= w_bd_nxt;
      r_data  <= w_data_nxt;
    end
  end

  // Bubble counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= {CNT_W{1'b0}};
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  assign valid_o      = r_valid;
  assign pc_o         = r_pc;
  assign instr_o      = r_instr;
  assign bd_o         = r_bd;
  assign data_o       = r_data;
  assign bubble_cnt_o = r_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg. It runs three instances from shared control inputs:
// keep-PC with 3x32 lanes and a 4-bit counter, zero-PC with the same shape,
// and 4x8 lanes with a 16-bit counter and RESET_PC=0x100.
// A behavioural model predicts every instance and is compared on each falling edge.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_i, flush_i, valid_i, bd_i, clr_cnt_i;
  logic [31:0] pc_i, instr_i;
  logic [95:0] data_i;
  logic [31:0] p_data_i;

  logic        k_valid, z_valid, p_valid;
  logic [31:0] k_pc, z_pc, p_pc, k_instr, z_instr, p_instr;
  logic        k_bd, z_bd, p_bd;
  logic [95:0] k_data, z_data;
  logic [31:0] p_data;
  logic [3:0]  k_cnt, z_cnt;
  logic [15:0] p_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(32), .NUM_LANES(3), .RESET_PC(32'h0), .FLUSH_KEEP_PC(1'b1), .CNT_W(4)) u_k (
    .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
    .pc_i(pc_i), .instr_i(instr_i), .bd_i(bd_i), .data_i(data_i), .clr_cnt_i(clr_cnt_i),
    .valid_o(k_valid), .pc_o(k_pc), .instr_o(k_instr), .bd_o(k_bd), .data_o(k_data),
    .bubble_cnt_o(k_cnt));

  pipe_stage_reg #(.DATA_W(32), .NUM_LANES(3), .RESET_PC(32'h0), .FLUSH_KEEP_PC(1'b0), .CNT_W(4)) u_z (
    .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
    .pc_i(pc_i), .instr_i(instr_i), .bd_i(bd_i), .data_i(data_i), .clr_cnt_i(clr_cnt_i),
    .valid_o(z_valid), .pc_o(z_pc), .instr_o(z_instr), .bd_o(z_bd), .data_o(z_data),
    .bubble_cnt_o(z_cnt));

  pipe_stage_reg #(.DATA_W(8), .NUM_LANES(4), .RESET_PC(32'h0000_0100), .FLUSH_KEEP_PC(1'b1), .CNT_W(16)) u_p (
    .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
    .pc_i(pc_i), .instr_i(instr_i), .bd_i(bd_i), .data_i(p_data_i), .clr_cnt_i(clr_cnt_i),
    .valid_o(p_valid), .pc_o(p_pc), .instr_o(p_instr), .bd_o(p_bd), .data_o(p_data),
    .bubble_cnt_o(p_cnt));

  // Behavioural model of one stage.
  typedef struct {
    bit          valid;
    logic [31:0] pc;
    logic [31:0] instr;
    bit          bd;
    logic [95:0] data;
    int          cnt;
  } mdl_t;

  mdl_t mk, mz, mp;

  function automatic mdl_t mdl_reset(input logic [31:0] rpc);
    mdl_t s;
    s.valid = 1'b0; s.pc = rpc; s.instr = 32'h0; s.bd = 1'b0; s.data = 96'h0; s.cnt = 0;
    return s;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t s, input bit keep_pc, input int cmax,
                                    input logic [95:0] din);
    mdl_t n;
    bit   bubble;
    n = s;
    bubble = 1'b0;
    if (flush_i) begin
      n.valid = 1'b0; n.instr = 32'h0; n.bd = 1'b0; n.data = 96'h0;
      n.pc = keep_pc ? pc_i : 32'h0;
      bubble = 1'b1;
    end else if (!stall_i) begin
      n.valid = valid_i; n.pc = pc_i; n.instr = instr_i; n.bd = bd_i; n.data = din;
      bubble = !valid_i;
    end
    if (clr_cnt_i) n.cnt = 0;
    else if (bubble) n.cnt = (s.cnt + 1 > cmax) ? cmax : s.cnt + 1;
    return n;
  endfunction

  // Model advances on the same edges as the design.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mk = mdl_reset(32'h0);
      mz = mdl_reset(32'h0);
      mp = mdl_reset(32'h0000_0100);
    end else begin
      mk = mdl_step(mk, 1'b1, 15, data_i);
      mz = mdl_step(mz, 1'b0, 15, data_i);
      mp = mdl_step(mp, 1'b1, 65535, {64'h0, p_data_i});
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every instance against the model on each falling edge.
  always @(negedge clk) begin
    chk("k.valid", 128'(k_valid), 128'(mk.valid));
    chk("k.pc",    128'(k_pc),    128'(mk.pc));
    chk("k.instr", 128'(k_instr), 128'(mk.instr));
    chk("k.bd",    128'(k_bd),    128'(mk.bd));
    chk("k.data",  128'(k_data),  128'(mk.data));
    chk("k.cnt",   128'(k_cnt),   128'(mk.cnt));
    chk("z.valid", 128'(z_valid), 128'(mz.valid));
    chk("z.pc",    128'(z_pc),    128'(mz.pc));
    chk("z.instr", 128'(z_instr), 128'(mz.instr));
    chk("z.data",  128'(z_data),  128'(mz.data));
    chk("z.cnt",   128'(z_cnt),   128'(mz.cnt));
    chk("p.valid", 128'(p_valid), 128'(mp.valid));
    chk("p.pc",    128'(p_pc),    128'(mp.pc));
    chk("p.bd",    128'(p_bd),    128'(mp.bd));
    chk("p.data",  128'(p_data),  128'(mp.data[31:0]));
    chk("p.cnt",   128'(p_cnt),   128'(mp.cnt));
  end

  // Drive one cycle of inputs, then wait for the next falling edge.
  task automatic cyc(input bit v, input logic [31:0] pc, input logic [31:0] ins, input bit bd,
                     input logic [95:0] d, input logic [31:0] pd,
                     input bit st, input bit fl, input bit clr);
    valid_i = v; pc_i = pc; instr_i = ins; bd_i = bd; data_i = d; p_data_i = pd;
    stall_i = st; flush_i = fl; clr_cnt_i = clr;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0;
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 96'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 32'h0, 1'b0, 96'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("rst.p.pc", 128'(p_pc), 128'h100);
    #1 reset = 1'b1;

    // Reset mid-stream.
    cyc(1'b1, 32'h3004, 32'h1111_2222, 1'b1, {32'd9, 32'd8, 32'd7}, 32'h0403_0201, 1'b0, 1'b0, 1'b0);
    chk("t1.pre.pc", 128'(k_pc), 128'h3004);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("t1.valid", 128'(k_valid), 128'h0);
    chk("t1.pc",    128'(k_pc),    128'h0);
    chk("t1.instr", 128'(k_instr), 128'h0);
    chk("t1.data",  128'(k_data),  128'h0);
    chk("t1.p.pc",  128'(p_pc),    128'h100);
    @(negedge clk);
    #1 reset = 1'b1;

    // Plain load.
    cyc(1'b1, 32'h3000, 32'h2401_0005, 1'b0, {32'd3, 32'd2, 32'd1}, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("t2.valid", 128'(k_valid), 128'h1);
    chk("t2.pc",    128'(k_pc),    128'h3000);
    chk("t2.instr", 128'(k_instr), 128'h2401_0005);
    chk("t2.data",  128'(k_data),  {32'h0, 32'd3, 32'd2, 32'd1});

    // Stall for three edges while the inputs change.
    for (int i = 0; i < 3; i++) begin
      cyc(i[0], 32'h3100 + 32'(i), 32'hABCD_0000 + 32'(i), 1'b1, {96{1'b1}}, 32'hFFFF_FFFF,
          1'b1, 1'b0, 1'b0);
    end
    chk("t3.hold.pc",  128'(k_pc),  128'h3000);
    chk("t3.hold.cnt", 128'(k_cnt), 128'h0);
    cyc(1'b1, 32'h3008, 32'h0000_0020, 1'b1, {32'd6, 32'd5, 32'd4}, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("t3.rel.pc", 128'(k_pc), 128'h3008);
    chk("t3.rel.bd", 128'(k_bd), 128'h1);

    // Flush together with stall.
    cyc(1'b1, 32'h3010, 32'h1234_5678, 1'b1, {32'd1, 32'd1, 32'd1}, 32'h55, 1'b1, 1'b1, 1'b0);
    chk("t4.k.pc",    128'(k_pc),    128'h3010);
    chk("t4.z.pc",    128'(z_pc),    128'h0);
    chk("t4.k.valid", 128'(k_valid), 128'h0);
    chk("t4.k.instr", 128'(k_instr), 128'h0);
    chk("t4.k.cnt",   128'(k_cnt),   128'h1);

    // An empty-slot load counts as a bubble but keeps its payload; stalled clear.
    cyc(1'b0, 32'h3014, 32'hCAFE_F00D, 1'b1, {32'd7, 32'd7, 32'd7}, 32'h77, 1'b0, 1'b0, 1'b0);
    chk("t4b.instr", 128'(k_instr), 128'hCAFE_F00D);
    chk("t4b.cnt",   128'(k_cnt),   128'h2);
    cyc(1'b1, 32'h3018, 32'h0, 1'b0, 96'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    chk("t4c.cnt", 128'(k_cnt), 128'h0);

    // Counter saturation and clear-with-flush.
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 32'h4000 + 32'(4 * i), 32'h1, 1'b0, 96'h1, 32'h1, 1'b0, 1'b1, 1'b0);
    end
    chk("t5.sat.k", 128'(k_cnt), 128'd15);
    chk("t5.sat.p", 128'(p_cnt), 128'd20);
    cyc(1'b1, 32'h5000, 32'h1, 1'b0, 96'h1, 32'h1, 1'b0, 1'b1, 1'b1);
    chk("t5.clr", 128'(k_cnt), 128'd0);

    // Lane packing on the 4x8 instance.
    cyc(1'b1, 32'h6000, 32'h2, 1'b0, 96'h0, 32'hDDCC_BBAA, 1'b0, 1'b0, 1'b0);
    chk("t6.data",  128'(p_data),       128'hDDCC_BBAA);
    chk("t6.lane2", 128'(p_data[23:16]), 128'hCC);

    cyc(1'b0, 32'h0, 32'h0, 1'b0, 96'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
